// File: rtl/mem_map_pkg.sv
// Shared address-map definitions for the data-side memory responder:
// MMIO register offsets, STATUS bit layout and the region decoder.
package mem_map_pkg;

   localparam logic [3:0] OFF_TX     = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLE  = 4'h8;
   localparam logic [3:0] OFF_ERR    = 4'hC;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_W   = 8;

   localparam int ERR_W = 16;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } regionT;

   function automatic regionT decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] ramBytes,
                                           input logic [27:0] mmioTag);
      if (addr < ramBytes)
         return REG_RAM;
      else if (addr[31:4] == mmioTag)
         return REG_MMIO;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-word output; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             pushData,
   input  logic                         pop,
   output logic [WIDTH-1:0]             popData,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign doPop   = pop & ~empty;
   assign doPush  = push & (~full | doPop);
   assign popData = empty ? '0 : store[rdPtr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (doPush) store[wrPtr] <= pushData;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: word RAM plus an MMIO window holding a TX FIFO,
// a free-running cycle counter and a saturating error counter.
module data_mem_responder
   import mem_map_pkg::*;
#(
   parameter int          RAM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwriteM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        err_o
);

   localparam int          IDX_W     = $clog2(RAM_WORDS);
   localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [27:0] MMIO_TAG  = MMIO_BASE[31:4];

   logic [31:0]      mem [RAM_WORDS];
   logic [31:0]      cycleCnt;
   logic [ERR_W-1:0] errCnt;

   regionT           region;
   logic             misaligned;
   logic [IDX_W-1:0] wordIdx;
   logic [3:0]       offset;
   logic             wrOk;
   logic             mmioWr;
   logic             ramWr;
   logic             txWr;
   logic             cycleWr;
   logic             errClr;
   logic             badWr;
   logic             dropErr;
   logic             pop;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [CNT_W-1:0] fifoCount;
   logic [31:0]      status;

   assign region     = decodeRegion(addrM, RAM_BYTES, MMIO_TAG);
   assign misaligned = |addrM[1:0];
   assign wordIdx    = addrM[IDX_W+1:2];
   assign offset     = addrM[3:0];

   assign wrOk    = memwriteM & ~misaligned;
   assign ramWr   = wrOk & (region == REG_RAM);
   assign mmioWr  = wrOk & (region == REG_MMIO);
   assign txWr    = mmioWr & (offset == OFF_TX);
   assign cycleWr = mmioWr & (offset == OFF_CYCLE);
   assign errClr  = mmioWr & (offset == OFF_ERR);
   assign badWr   = memwriteM & (misaligned | (region == REG_NONE));

   assign pop       = out_valid & out_ready;
   assign dropErr   = txWr & fifoFull & ~pop;
   assign out_valid = ~fifoEmpty;
   assign err_o     = |errCnt;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (txWr),
      .pushData (writedataM),
      .pop      (pop),
      .popData  (out_data),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   always_comb begin
      status                            = '0;
      status[ST_EMPTY]                  = fifoEmpty;
      status[ST_FULL]                   = fifoFull;
      status[ST_COUNT_LSB +: CNT_W]     = fifoCount;
   end

   // Reads never change state; a same-cycle RAM write is seen next cycle.
   always_comb begin
      readdataM = '0;
      if (!misaligned) begin
         case (region)
            REG_RAM:  readdataM = mem[wordIdx];
            REG_MMIO: begin
               case (offset)
                  OFF_STATUS: readdataM = status;
                  OFF_CYCLE:  readdataM = cycleCnt;
                  OFF_ERR:    readdataM = {{(32-ERR_W){1'b0}}, errCnt};
                  default:    readdataM = '0;
               endcase
            end
            default:  readdataM = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ramWr) mem[wordIdx] <= writedataM;
   end

   // Clearing the error count takes priority over any same-cycle error event.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycleCnt <= '0;
         errCnt   <= '0;
      end else begin
         cycleCnt <= cycleWr ? writedataM : cycleCnt + 32'd1;
         if (errClr)
            errCnt <= '0;
         else if ((badWr || dropErr) && errCnt != '1)
            errCnt <= errCnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a queue-based reference model
// predicts reads and FIFO output words; a negedge monitor compares them.
module tb_data_mem_responder;

   localparam int          RAM_WORDS  = 1024;
   localparam int          FIFO_DEPTH = 8;
   localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
   localparam logic [31:0] A_TX       = MMIO_BASE + 32'h0;
   localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'h4;
   localparam logic [31:0] A_CYCLE    = MMIO_BASE + 32'h8;
   localparam logic [31:0] A_ERR      = MMIO_BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwriteM = 1'b0;
   logic [31:0] addrM = '0;
   logic [31:0] writedataM = '0;
   logic [31:0] readdataM;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic        err_o;

   always #5 clk = ~clk;

   data_mem_responder #(
      .RAM_WORDS  (RAM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .MMIO_BASE  (MMIO_BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .memwriteM  (memwriteM),
      .addrM      (addrM),
      .writedataM (writedataM),
      .readdataM  (readdataM),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .err_o      (err_o)
   );

   typedef struct {
      bit          chk;
      logic [31:0] val;
   } rdExpT;

   rdExpT       rdQ[$];
   logic [31:0] expQ[$];
   logic [31:0] mFifo[$];
   logic [31:0] mRam [RAM_WORDS];
   bit          mRamOk [RAM_WORDS];
   logic [31:0] mCycle = '0;
   logic [15:0] mErr = '0;
   bit          started = 1'b0;
   int          nChecks = 0;
   int          nFails = 0;
   rdExpT       monExp;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic rdExpT modelRead(input logic [31:0] a);
      rdExpT r;
      int    idx;
      r.chk = 1'b1;
      r.val = '0;
      idx   = int'(a[11:2]);
      if (a[1:0] != 2'b00) begin
         r.val = '0;
      end else if (a < 32'(RAM_WORDS * 4)) begin
         r.chk = mRamOk[idx];
         r.val = mRam[idx];
      end else if (a[31:4] == MMIO_BASE[31:4]) begin
         case (a[3:0])
            4'h4: begin
               r.val = 32'(mFifo.size()) << 8;
               if (mFifo.size() == FIFO_DEPTH) r.val[1] = 1'b1;
               if (mFifo.size() == 0)          r.val[0] = 1'b1;
            end
            4'h8:    r.val = mCycle;
            4'hC:    r.val = {16'h0, mErr};
            default: r.val = '0;
         endcase
      end
      return r;
   endfunction

   task automatic modelUpdate(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic rdy, input logic rst);
      bit          popNow;
      bit          pushNow;
      bit          errInc;
      bit          clr;
      logic [31:0] nextCycle;
      int          idx;
      if (rst) begin
         mFifo.delete();
         expQ.delete();
         mCycle = '0;
         mErr   = '0;
      end else begin
         popNow    = (mFifo.size() > 0) && rdy;
         pushNow   = 1'b0;
         errInc    = 1'b0;
         clr       = 1'b0;
         nextCycle = mCycle + 32'd1;
         idx       = int'(a[11:2]);
         if (we) begin
            if (a[1:0] != 2'b00) begin
               errInc = 1'b1;
            end else if (a < 32'(RAM_WORDS * 4)) begin
               mRam[idx]   = wd;
               mRamOk[idx] = 1'b1;
            end else if (a[31:4] == MMIO_BASE[31:4]) begin
               case (a[3:0])
                  4'h0: begin
                     if (mFifo.size() < FIFO_DEPTH || popNow) pushNow = 1'b1;
                     else errInc = 1'b1;
                  end
                  4'h8:    nextCycle = wd;
                  4'hC:    clr = 1'b1;
                  default: ;
               endcase
            end else begin
               errInc = 1'b1;
            end
         end
         if (popNow) void'(mFifo.pop_front());
         if (pushNow) begin
            mFifo.push_back(wd);
            expQ.push_back(wd);
         end
         if (clr) mErr = '0;
         else if (errInc && mErr != 16'hFFFF) mErr = mErr + 16'd1;
         mCycle = nextCycle;
      end
   endtask

   // One cycle of stimulus: drive, predict the read, then advance the model at the edge.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic rst);
      reset      = rst;
      memwriteM  = we;
      addrM      = a;
      writedataM = wd;
      out_ready  = rdy;
      rdQ.push_back(modelRead(a));
      @(posedge clk);
      modelUpdate(we, a, wd, rdy, rst);
      #1;
   endtask

   always @(negedge clk) begin
      if (rdQ.size() > 0) begin
         monExp = rdQ.pop_front();
         if (started && monExp.chk) check("readdataM", readdataM, monExp.val);
      end
      if (started) begin
         check("out_valid", 32'(out_valid), 32'(mFifo.size() > 0));
         check("err_o", 32'(err_o), 32'(mErr != 16'h0));
         if (out_valid) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL out_data: valid with no expected word, actual %h", out_data);
            end else begin
               check("out_data", out_data, expQ[0]);
               if (out_ready) void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clk);
      #1;
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      started = 1'b1;
      step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_CYCLE,  32'h0, 1'b0, 1'b0);

      for (int i = 0; i < RAM_WORDS; i++)
         step(1'b1, 32'(i) << 2, $urandom, 1'b0, 1'b0);

      // RAM write then read, and read-during-write returning the old word
      step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
      step(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h10, 32'h1, 1'b0, 1'b0);
      step(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

      // two TX words held, then drained
      step(1'b1, A_TX, 32'hA, 1'b0, 1'b0);
      step(1'b1, A_TX, 32'hB, 1'b0, 1'b0);
      step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, A_STATUS, 32'h0, 1'b1, 1'b0);
      step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);

      // overflow drop, then push-with-pop while full
      for (int i = 0; i < 9; i++) step(1'b1, A_TX, 32'h100 + 32'(i), 1'b0, 1'b0);
      step(1'b0, A_ERR, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);
      step(1'b1, A_TX, 32'h200, 1'b1, 1'b0);
      step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_ERR, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, A_STATUS, 32'h0, 1'b1, 1'b0);

      // cycle counter write and wrap
      step(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b0);

      // misaligned and unmapped writes count errors without side effects
      step(1'b1, A_ERR, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h6, 32'h5555_5555, 1'b0, 1'b0);
      step(1'b1, 32'h8000_0000, 32'h6666_6666, 1'b0, 1'b0);
      step(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h6, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_ERR, 32'h0, 1'b0, 1'b0);
      step(1'b1, A_ERR, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_ERR, 32'h0, 1'b0, 1'b0);

      // reset mid-operation keeps RAM, drops FIFO and counters
      step(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0);
      step(1'b1, 32'h3, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, A_TX, 32'h300 + 32'(i), 1'b0, 1'b0);
      step(1'b1, A_CYCLE, 32'd100, 1'b0, 1'b0);
      step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1);
      step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b0);
      step(1'b0, A_ERR, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         int          k;
         logic        we;
         logic        rdy;
         logic        rst;
         logic [31:0] a;
         k   = int'($urandom_range(0, 9));
         we  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 299) == 0);
         case (k)
            0, 1, 2:    a = 32'($urandom_range(0, RAM_WORDS - 1)) << 2;
            3:          a = (32'($urandom_range(0, RAM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
            4, 5, 6, 7: a = MMIO_BASE | (32'($urandom_range(0, 3)) << 2);
            8:          a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            default:    a = MMIO_BASE | 32'($urandom_range(0, 15));
         endcase
         step(we, a, $urandom, rdy, rst);
      end

      for (int i = 0; i < 12; i++) step(1'b0, A_STATUS, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
